mem_bus_adapter: RTL and testbench

Parametrised external-bus adapter between the `v810_mem` external bus (32-bit data, `BEn`/`DAn`/`READYn`/`SZRQn`) and a synchronous memory of 8, 16 or 32 bits.
- Splits each 32-bit bus cycle into one or more memory beats, skipping beats whose byte lanes are all disabled.
- Inserts a run-time-programmable number of wait states per beat, assembles read data and drives write data per beat.
- Returns a single `READYn` pulse to the controller.
- Sits in the system or bench between `v810_mem` and ROM/RAM models, and supports writes.

---
 rtl/mem_bus_adapter.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_bus_adapter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_adapter.sv
// mem_bus_adapter: splits 32-bit v810_mem bus cycles into MDW-wide memory beats with programmable waits.
// Optional `MEM_BUS_ADAPTER_SZRQ_EN (MDW=16 only): one beat per request, upper half requested via CTLR_SZRQn.
module mem_bus_adapter #(
  parameter int AW  = 18,
  parameter int MDW = 16,
  parameter int WSW = 4
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             CE,
  input  logic [WSW-1:0]   WS,
  input  logic [31:0]      CTLR_A,
  input  logic             CTLR_DAn,
  input  logic [3:0]       CTLR_BEn,
  input  logic             CTLR_RW,
  input  logic [31:0]      CTLR_DO,
  output logic [31:0]      CTLR_DI,
  output logic             CTLR_READYn,
  output logic             CTLR_SZRQn,
  output logic             MEM_nCE,
  output logic             MEM_nWE,
  output logic             MEM_nOE,
  output logic [MDW/8-1:0] MEM_nBE,
  output logic [AW-1:0]    MEM_A,
  output logic [MDW-1:0]   MEM_DI,
  input  logic [MDW-1:0]   MEM_DO
);

  localparam int N   = 32 / MDW;
  localparam int BPB = MDW / 8;
  localparam int L   = $clog2(BPB);
  localparam int LN  = $clog2(N);
  localparam int KW  = (N > 1) ? LN : 1;

  typedef enum logic [1:0] {IDLE, BEAT, CAPT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [KW-1:0]   k_reg, k_next;
  logic [WSW-1:0]  wait_reg, wait_next;
  logic [WSW-1:0]  ws_reg, ws_next;
  logic [31:0]     a_reg, a_next;
  logic [31:0]     do_reg, do_next;
  logic [3:0]      ben_reg, ben_next;
  logic            rw_reg, rw_next;
  logic [N-1:0]    mask_reg, mask_next;
  logic            split_reg, split_next;

  logic            ce_n_reg, ce_n_next;
  logic            we_n_reg, we_n_next;
  logic            oe_n_reg, oe_n_next;
  logic [BPB-1:0]  be_n_reg, be_n_next;
  logic [AW-1:0]   mem_a_reg, mem_a_next;
  logic [MDW-1:0]  mem_di_reg, mem_di_next;
  logic            ready_n_reg, ready_n_next;
  logic            szrq_n_reg, szrq_n_next;

  logic [N-1:0]    req_mask;
  logic [KW:0]     req_first;
  logic [KW:0]     adv;
  logic            req_split;
  logic            go;

  // Beat k is active when any of its byte lanes is enabled.
  function automatic logic [N-1:0] beat_mask(input logic [3:0] ben);
    logic [N-1:0] m;
    m = '0;
    for (int b = 0; b < N; b++) m[b] = ~&ben[b*BPB +: BPB];
`ifdef MEM_BUS_ADAPTER_SZRQ_EN
    if (MDW == 16 && m[0]) m = N'(1);
`endif
    return m;
  endfunction

  // Returns {valid, index} of the lowest active beat at or above 'from'.
  function automatic logic [KW:0] first_from(input logic [N-1:0] m, input int from);
    logic [KW:0] r;
    r = '0;
    for (int j = N - 1; j >= 0; j--)
      if (j >= from && m[j]) r = {1'b1, KW'(j)};
    return r;
  endfunction

`ifdef MEM_BUS_ADAPTER_SZRQ_EN
  assign req_split = (MDW == 16) && !(&CTLR_BEn[1:0]) && !(&CTLR_BEn[3:2]);
`else
  assign req_split = 1'b0;
`endif

  always_comb begin
    req_mask  = beat_mask(CTLR_BEn);
    req_first = first_from(req_mask, 0);
    adv       = first_from(mask_reg, int'(k_reg) + 1);
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    wait_next  = wait_reg;
    ws_next    = ws_reg;
    a_next     = a_reg;
    do_next    = do_reg;
    ben_next   = ben_reg;
    rw_next    = rw_reg;
    mask_next  = mask_reg;
    split_next = split_reg;
    go         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!CTLR_DAn) begin
          a_next     = CTLR_A;
          do_next    = CTLR_DO;
          ben_next   = CTLR_BEn;
          rw_next    = CTLR_RW;
          ws_next    = WS;
          wait_next  = WS;
          mask_next  = req_mask;
          split_next = req_split;
          if (req_first[KW]) begin
            state_next = BEAT;
            k_next     = req_first[KW-1:0];
          end else begin
            state_next = DONE;
          end
        end
      end
      BEAT: begin
        if (wait_reg != '0) wait_next = wait_reg - WSW'(1);
        else if (rw_reg)    state_next = CAPT;
        else                go = 1'b1;
      end
      CAPT:    go = 1'b1;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (go) begin
      if (adv[KW]) begin
        state_next = BEAT;
        k_next     = adv[KW-1:0];
        wait_next  = ws_reg;
      end else begin
        state_next = DONE;
      end
    end
  end

  // Output registers are loaded with the values belonging to the state being entered.
  always_comb begin
    ce_n_next    = 1'b1;
    we_n_next    = 1'b1;
    oe_n_next    = 1'b1;
    be_n_next    = '1;
    mem_a_next   = mem_a_reg;
    mem_di_next  = mem_di_reg;
    ready_n_next = (state_next != DONE);
    szrq_n_next  = !(state_next == DONE && split_next);
    if (state_next == BEAT) begin
      ce_n_next  = 1'b0;
      oe_n_next  = !rw_next;
      we_n_next  = rw_next;
      be_n_next  = ben_next[int'(k_next)*BPB +: BPB];
      mem_a_next = AW'(a_next >> L);
      if (N > 1) mem_a_next[KW-1:0] = k_next;
      if (!rw_next) mem_di_next = do_next[int'(k_next)*MDW +: MDW];
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_reg   <= IDLE;
      k_reg       <= '0;
      wait_reg    <= '0;
      ws_reg      <= '0;
      a_reg       <= '0;
      do_reg      <= '0;
      ben_reg     <= '1;
      rw_reg      <= 1'b1;
      mask_reg    <= '0;
      split_reg   <= 1'b0;
      ce_n_reg    <= 1'b1;
      we_n_reg    <= 1'b1;
      oe_n_reg    <= 1'b1;
      be_n_reg    <= '1;
      mem_a_reg   <= '0;
      mem_di_reg  <= '0;
      ready_n_reg <= 1'b1;
      szrq_n_reg  <= 1'b1;
    end else if (CE) begin
      state_reg   <= state_next;
      k_reg       <= k_next;
      wait_reg    <= wait_next;
      ws_reg      <= ws_next;
      a_reg       <= a_next;
      do_reg      <= do_next;
      ben_reg     <= ben_next;
      rw_reg      <= rw_next;
      mask_reg    <= mask_next;
      split_reg   <= split_next;
      ce_n_reg    <= ce_n_next;
      we_n_reg    <= we_n_next;
      oe_n_reg    <= oe_n_next;
      be_n_reg    <= be_n_next;
      mem_a_reg   <= mem_a_next;
      mem_di_reg  <= mem_di_next;
      ready_n_reg <= ready_n_next;
      szrq_n_reg  <= szrq_n_next;
    end
  end

  // Read-data byte lanes: cleared on accept, loaded from MEM_DO at the edge ending CAPT of their beat.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_reg;
    always_ff @(posedge CLK) begin
      if (RES) begin
        lane_reg <= '0;
      end else if (CE) begin
        if (state_reg == IDLE && !CTLR_DAn)
          lane_reg <= '0;
        else if (state_reg == CAPT && int'(k_reg) == gi / BPB && !ben_reg[gi])
          lane_reg <= MEM_DO[(gi % BPB)*8 +: 8];
      end
    end
    assign CTLR_DI[gi*8 +: 8] = lane_reg;
  end

  assign MEM_nCE     = ce_n_reg;
  assign MEM_nWE     = we_n_reg;
  assign MEM_nOE     = oe_n_reg;
  assign MEM_nBE     = be_n_reg;
  assign MEM_A       = mem_a_reg;
  assign MEM_DI      = mem_di_reg;
  assign CTLR_READYn = ready_n_reg;
  assign CTLR_SZRQn  = szrq_n_reg;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Directed bench for mem_bus_adapter: 16-, 8- and 32-bit memory instances with registered-read models.
// Expected values for the 16-bit read path change when MEM_BUS_ADAPTER_SZRQ_EN is defined.
module tb_mem_bus_adapter;

`ifdef MEM_BUS_ADAPTER_SZRQ_EN
  localparam int          R16_LAT  = 3;
  localparam int          R16_NCE  = 1;
  localparam logic [31:0] R16_DI   = 32'h0000_1234;
  localparam logic        R16_SZRQ = 1'b0;
  localparam int          RST_CYC  = 3;
  localparam logic [31:0] RST_ADDR = 32'h40;
`else
  localparam int          R16_LAT  = 5;
  localparam int          R16_NCE  = 2;
  localparam logic [31:0] R16_DI   = 32'hABCD_1234;
  localparam logic        R16_SZRQ = 1'b1;
  localparam int          RST_CYC  = 7;
  localparam logic [31:0] RST_ADDR = 32'h41;
`endif

  logic        clk, res, ce, rw, mem_load;
  logic [2:0]  dan;
  logic [3:0]  ben, ws;
  logic [31:0] ctlr_a, cdo;

  logic [31:0] di16, di8, di32;
  logic        rdy16, rdy8, rdy32, szrq16, szrq8, szrq32;
  logic        nce16, nwe16, noe16, nce8, nwe8, noe8, nce32, nwe32, noe32;
  logic [1:0]  nbe16;
  logic [0:0]  nbe8;
  logic [3:0]  nbe32;
  logic [11:0] ma16, ma8, ma32;
  logic [15:0] mdi16, mdo16;
  logic [7:0]  mdi8, mdo8;
  logic [31:0] mdi32, mdo32;

  logic [15:0] mem16 [0:4095];
  logic [7:0]  mem8  [0:4095];
  logic [31:0] mem32 [0:4095];

  int checks = 0;
  int errors = 0;

  mem_bus_adapter #(.AW(12), .MDW(16), .WSW(4)) u16 (
    .CLK(clk), .RES(res), .CE(ce), .WS(ws), .CTLR_A(ctlr_a), .CTLR_DAn(dan[0]),
    .CTLR_BEn(ben), .CTLR_RW(rw), .CTLR_DO(cdo), .CTLR_DI(di16), .CTLR_READYn(rdy16),
    .CTLR_SZRQn(szrq16), .MEM_nCE(nce16), .MEM_nWE(nwe16), .MEM_nOE(noe16),
    .MEM_nBE(nbe16), .MEM_A(ma16), .MEM_DI(mdi16), .MEM_DO(mdo16));

  mem_bus_adapter #(.AW(12), .MDW(8), .WSW(4)) u8 (
    .CLK(clk), .RES(res), .CE(ce), .WS(ws), .CTLR_A(ctlr_a), .CTLR_DAn(dan[1]),
    .CTLR_BEn(ben), .CTLR_RW(rw), .CTLR_DO(cdo), .CTLR_DI(di8), .CTLR_READYn(rdy8),
    .CTLR_SZRQn(szrq8), .MEM_nCE(nce8), .MEM_nWE(nwe8), .MEM_nOE(noe8),
    .MEM_nBE(nbe8), .MEM_A(ma8), .MEM_DI(mdi8), .MEM_DO(mdo8));

  mem_bus_adapter #(.AW(12), .MDW(32), .WSW(4)) u32 (
    .CLK(clk), .RES(res), .CE(ce), .WS(ws), .CTLR_A(ctlr_a), .CTLR_DAn(dan[2]),
    .CTLR_BEn(ben), .CTLR_RW(rw), .CTLR_DO(cdo), .CTLR_DI(di32), .CTLR_READYn(rdy32),
    .CTLR_SZRQn(szrq32), .MEM_nCE(nce32), .MEM_nWE(nwe32), .MEM_nOE(noe32),
    .MEM_nBE(nbe32), .MEM_A(ma32), .MEM_DI(mdi32), .MEM_DO(mdo32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories: one-cycle read latency, byte-masked writes, output held when not read.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 4096; i++) begin
        mem16[i] <= 16'hC3C3;
        mem8[i]  <= 8'hA5;
        mem32[i] <= 32'h5A5A_5A5A;
      end
      mem16[12'h40] <= 16'h1234;
      mem16[12'h41] <= 16'hABCD;
      mem32[12'h20] <= 32'hDEAD_BEEF;
    end else begin
      if (!nce16 && !noe16) mdo16 <= mem16[ma16];
      if (!nce16 && !nwe16) begin
        if (!nbe16[0]) mem16[ma16][7:0]  <= mdi16[7:0];
        if (!nbe16[1]) mem16[ma16][15:8] <= mdi16[15:8];
      end
      if (!nce8 && !noe8) mdo8 <= mem8[ma8];
      if (!nce8 && !nwe8 && !nbe8[0]) mem8[ma8] <= mdi8;
      if (!nce32 && !noe32) mdo32 <= mem32[ma32];
      if (!nce32 && !nwe32) begin
        for (int b = 0; b < 4; b++)
          if (!nbe32[b]) mem32[ma32][b*8 +: 8] <= mdi32[b*8 +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_nce(input int w);
    case (w)
      0:       return nce16;
      1:       return nce8;
      default: return nce32;
    endcase
  endfunction

  function automatic logic get_rdy(input int w);
    case (w)
      0:       return rdy16;
      1:       return rdy8;
      default: return rdy32;
    endcase
  endfunction

  function automatic logic get_szrq(input int w);
    case (w)
      0:       return szrq16;
      1:       return szrq8;
      default: return szrq32;
    endcase
  endfunction

  function automatic logic [31:0] get_di(input int w);
    case (w)
      0:       return di16;
      1:       return di8;
      default: return di32;
    endcase
  endfunction

  function automatic logic [31:0] get_ma(input int w);
    case (w)
      0:       return {20'd0, ma16};
      1:       return {20'd0, ma8};
      default: return {20'd0, ma32};
    endcase
  endfunction

  // Issues one request; latency is the cycle index (edge 0 = acceptance) in which READYn is low.
  task automatic run_req(input string tag, input int which, input logic [31:0] a,
                         input logic [3:0] be, input logic r, input logic [31:0] d,
                         input logic [3:0] w, input bit ce_toggle,
                         output int lat, output int nce_lo, output logic [31:0] first_a,
                         output logic szrq_done, output logic rdy_after);
    ctlr_a = a; ben = be; rw = r; cdo = d; ws = w; ce = 1'b1;
    dan[which] = 1'b0;
    step();
    dan[which] = 1'b1;
    if (ce_toggle) ce = 1'b0;
    lat = -1; nce_lo = 0; first_a = get_ma(which); szrq_done = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      if (!get_nce(which)) nce_lo++;
      if (!get_rdy(which)) begin
        lat = c;
        szrq_done = get_szrq(which);
        break;
      end
      step();
      if (ce_toggle) ce = ~ce;
    end
    step();
    rdy_after = get_rdy(which);
    ce = 1'b1;
    $display("txn %s: lat=%0d nce_low=%0d di=%h addr0=%h", tag, lat, nce_lo, get_di(which), first_a);
  endtask

  int          lat, nce_lo, lowcnt;
  logic [31:0] fa;
  logic        szq, rda;

  initial begin
    res = 1'b1; ce = 1'b1; dan = 3'b111; ctlr_a = '0; ben = 4'hF; rw = 1'b1;
    cdo = '0; ws = '0; mem_load = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_load = 1'b0;
    res = 1'b0;

    check("rst_nce", nce16, 1'b1);
    check("rst_nwe", nwe16, 1'b1);
    check("rst_noe", noe16, 1'b1);
    check("rst_nbe", nbe16, 2'b11);
    check("rst_mem_a", ma16, 12'h0);
    check("rst_mem_di", mdi16, 16'h0);
    check("rst_di", di16, 32'h0);
    check("rst_ready", rdy16, 1'b1);
    check("rst_szrq", szrq16, 1'b1);

    // 16-bit read, WS=0, all lanes
    run_req("rd16", 0, 32'h80, 4'b0000, 1'b1, 32'h0, 4'd0, 1'b0, lat, nce_lo, fa, szq, rda);
    check("rd16_lat", lat, R16_LAT);
    check("rd16_nce", nce_lo, R16_NCE);
    check("rd16_addr0", fa, 32'h40);
    check("rd16_di", di16, R16_DI);
    check("rd16_szrq", szq, R16_SZRQ);
    check("rd16_ready_one", rda, 1'b1);

    // All lanes disabled: straight to DONE, data cleared
    run_req("rd16_none", 0, 32'h80, 4'b1111, 1'b1, 32'h0, 4'd0, 1'b0, lat, nce_lo, fa, szq, rda);
    check("none_lat", lat, 1);
    check("none_nce", nce_lo, 0);
    check("none_di", di16, 32'h0);
    check("none_ready_one", rda, 1'b1);

    // Reset during a WS=3 read beat, then no READYn
    ctlr_a = 32'h80; ben = 4'b0000; rw = 1'b1; ws = 4'd3;
    dan[0] = 1'b0;
    step();
    dan[0] = 1'b1;
    repeat (RST_CYC - 1) step();
    check("prerst_nce", nce16, 1'b0);
    check("prerst_addr", ma16, RST_ADDR[11:0]);
    res = 1'b1;
    step();
    res = 1'b0;
    check("midrst_nce", nce16, 1'b1);
    check("midrst_noe", noe16, 1'b1);
    check("midrst_nwe", nwe16, 1'b1);
    check("midrst_nbe", nbe16, 2'b11);
    check("midrst_addr", ma16, 12'h0);
    check("midrst_di", di16, 32'h0);
    check("midrst_ready", rdy16, 1'b1);
    lowcnt = 0;
    repeat (8) begin
      step();
      if (!rdy16) lowcnt++;
    end
    check("midrst_no_ready", lowcnt, 0);

    run_req("rd16_after_rst", 0, 32'h80, 4'b0000, 1'b1, 32'h0, 4'd0, 1'b0, lat, nce_lo, fa, szq, rda);
    check("rerd_lat", lat, R16_LAT);
    check("rerd_di", di16, R16_DI);

    // Upper-half write with WS=3: nCE low for 4 cycles
    run_req("wr16_hi", 0, 32'h80, 4'b0011, 1'b0, 32'h5566_7788, 4'd3, 1'b0, lat, nce_lo, fa, szq, rda);
    check("wr16_lat", lat, 5);
    check("wr16_nce", nce_lo, 4);
    check("wr16_addr0", fa, 32'h41);
    check("wr16_mem41", mem16[12'h41], 16'h5566);
    check("wr16_mem40", mem16[12'h40], 16'h1234);

    // 8-bit write, WS=2, lanes 0 and 3 enabled (BEn active-low)
    run_req("wr8", 1, 32'h10, 4'b0110, 1'b0, 32'h1122_3344, 4'd2, 1'b0, lat, nce_lo, fa, szq, rda);
    check("wr8_lat", lat, 7);
    check("wr8_nce", nce_lo, 6);
    check("wr8_addr0", fa, 32'h10);
    check("wr8_mem10", mem8[12'h10], 8'h44);
    check("wr8_mem11", mem8[12'h11], 8'hA5);
    check("wr8_mem12", mem8[12'h12], 8'hA5);
    check("wr8_mem13", mem8[12'h13], 8'h11);

    // 8-bit single-lane read, then full read
    run_req("rd8_lane0", 1, 32'h10, 4'b1110, 1'b1, 32'h0, 4'd0, 1'b0, lat, nce_lo, fa, szq, rda);
    check("rd8b_lat", lat, 3);
    check("rd8b_nce", nce_lo, 1);
    check("rd8b_di", di8, 32'h0000_0044);
    run_req("rd8_all", 1, 32'h10, 4'b0000, 1'b1, 32'h0, 4'd0, 1'b0, lat, nce_lo, fa, szq, rda);
    check("rd8_lat", lat, 9);
    check("rd8_nce", nce_lo, 4);
    check("rd8_di", di8, 32'h11A5_A544);
    check("rd8_szrq", szq, 1'b1);

    // 32-bit read WS=1, then the same read with CE toggling
    run_req("rd32", 2, 32'h80, 4'b0000, 1'b1, 32'h0, 4'd1, 1'b0, lat, nce_lo, fa, szq, rda);
    check("rd32_lat", lat, 4);
    check("rd32_nce", nce_lo, 2);
    check("rd32_addr0", fa, 32'h20);
    check("rd32_di", di32, 32'hDEAD_BEEF);
    run_req("rd32_ce", 2, 32'h80, 4'b0000, 1'b1, 32'h0, 4'd1, 1'b1, lat, nce_lo, fa, szq, rda);
    check("rd32ce_lat", lat, 7);
    check("rd32ce_nce", nce_lo, 4);
    check("rd32ce_di", di32, 32'hDEAD_BEEF);
    check("rd32ce_ready_held", rda, 1'b0);
    step();
    check("rd32ce_ready_end", rdy32, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
